// File: rtl/timing_sequencer.sv
// Raster timing generator: pixel/line counters with sync decodes, a frame counter,
// and a one-line-ahead prefetch request handshake with sticky underrun detection.
module timing_sequencer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       line_ack,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic [7:0] frame,
    output logic       line_req,
    output logic [9:0] line_y,
    output logic       underrun
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT_W     = 10'(H_ACTIVE);
    localparam logic [9:0] H_REQ_W     = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_LAST_W    = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SYNC_LO_W = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_HI_W = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT_W     = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST_W    = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_SYNC_LO_W = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_HI_W = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] frame_q, frame_d;
    state_t     state_q, state_d;
    logic [9:0] line_y_q, line_y_d;
    logic       underrun_q, underrun_d;

    logic       x_last;
    logic       y_last;
    logic [9:0] y_next;

    always_comb begin
        x_last  = (x_q == H_LAST_W);
        y_last  = (y_q == V_LAST_W);
        y_next  = y_last ? '0 : y_q + 10'd1;
        x_d     = x_q;
        y_d     = y_q;
        frame_d = frame_q;
        if (run) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_next;
                if (y_last) begin
                    frame_d = frame_q + 8'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // An ack always completes a pending request, even while the counters are frozen.
    always_comb begin
        state_d    = state_q;
        line_y_d   = line_y_q;
        underrun_d = underrun_q;
        case (state_q)
            IDLE: begin
                if (run && (x_q == H_REQ_W) && (y_next < V_ACT_W)) begin
                    state_d  = REQ;
                    line_y_d = y_next;
                end
            end
            REQ: begin
                if (line_ack) begin
                    state_d = IDLE;
                end else if (run && x_last) begin
                    state_d    = IDLE;
                    underrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q        <= '0;
            y_q        <= '0;
            frame_q    <= '0;
            state_q    <= IDLE;
            line_y_q   <= '0;
            underrun_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            frame_q    <= frame_d;
            state_q    <= state_d;
            line_y_q   <= line_y_d;
            underrun_q <= underrun_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign frame       = frame_q;
    assign line_y      = line_y_q;
    assign underrun    = underrun_q;
    assign line_req    = (state_q == REQ);
    assign active      = (x_q < H_ACT_W) && (y_q < V_ACT_W);
    assign hsync       = !((x_q >= H_SYNC_LO_W) && (x_q < H_SYNC_HI_W));
    assign vsync       = !((y_q >= V_SYNC_LO_W) && (y_q < V_SYNC_HI_W));
    assign frame_start = run && (x_q == '0) && (y_q == '0);

endmodule

// File: tb/tb_timing_sequencer.sv
// Bench for timing_sequencer on a reduced raster (32 x 19) so several frames fit in a short run.
module tb_timing_sequencer;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 32
    localparam int VT = VA + VF + VS + VB;   // 19
    localparam int FT = HT * VT;             // 608

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       line_ack = 1'b0;
    logic [9:0] x, y, line_y;
    logic [7:0] frame;
    logic       active, hsync, vsync, frame_start, line_req, underrun;

    int checks = 0;
    int failures = 0;
    int ack_mode = 0;  // 0 none, 1 immediate, 2 skip line 11, 3 late/idle-ack, 4 manual

    timing_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .line_ack(line_ack),
        .x(x), .y(y), .active(active), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start), .frame(frame), .line_req(line_req),
        .line_y(line_y), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: raster position as a single pixel index within the frame;
    // a request is a pending flag with a line number and a deadline at line end.
    int unsigned p = 0;
    int unsigned m_frame = 0;
    bit          m_pend = 0;
    int unsigned m_ly = 0;
    bit          m_und = 0;
    bit          m_valid = 0;

    always @(posedge clk) begin
        if (reset) begin
            p = 0; m_frame = 0; m_pend = 0; m_ly = 0; m_und = 0; m_valid = 1;
        end else begin
            if (m_pend && line_ack) begin
                m_pend = 0;
            end else if (m_pend && run && (p % HT) == HT - 1) begin
                m_pend = 0;
                m_und  = 1;
            end else if (!m_pend && run && (p % HT) == HA - 1
                         && ((p / HT + 1) % VT) < VA) begin
                m_pend = 1;
                m_ly   = (p / HT + 1) % VT;
            end
            if (run) begin
                p = (p + 1) % FT;
                if (p == 0) m_frame = (m_frame + 1) % 256;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                int mx, my;
                mx = int'(p % HT);
                my = int'(p / HT);
                check("x", int'(x), mx);
                check("y", int'(y), my);
                check("frame", int'(frame), int'(m_frame));
                check("active", int'(active), int'(mx < HA && my < VA));
                check("hsync", int'(hsync), int'(!(mx >= HA + HF && mx < HA + HF + HS)));
                check("vsync", int'(vsync), int'(!(my >= VA + VF && my < VA + VF + VS)));
                check("frame_start", int'(frame_start), int'(run && mx == 0 && my == 0));
                check("line_req", int'(line_req), int'(m_pend));
                check("line_y", int'(line_y), int'(m_ly));
                check("underrun", int'(underrun), int'(m_und));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            case (ack_mode)
                0: line_ack = 1'b0;
                1: line_ack = line_req;
                2: line_ack = line_req && (line_y != 10'd11);
                3: line_ack = (x == 10'(HA - 1)) || (line_req && x == 10'(HT - 1));
                default: ;
            endcase
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pos(input int xx, input int yy);
        int n = 0;
        while (!(int'(x) == xx && int'(y) == yy) && n < 2 * FT) begin
            step();
            n++;
        end
        if (n >= 2 * FT) begin
            checks++;
            failures++;
            $display("FAIL wait_pos: x/y never reached %0d/%0d (at %0d/%0d)", xx, yy, x, y);
        end
    endtask

    initial begin
        int fs_seen, last_fs, hs_low, vs_low, hs_first, vs_first;
        int reqs, first_ly, last_ly, last_req_y, fr0;

        // Reset state
        repeat (3) step();
        reset = 1'b0;
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_frame", int'(frame), 0);
        check("rst_line_req", int'(line_req), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_active", int'(active), 1);
        check("rst_hsync", int'(hsync), 1);
        check("rst_vsync", int'(vsync), 1);
        check("rst_fs_run0", int'(frame_start), 0);
        run = 1'b1;
        #1;
        check("rst_fs_run1", int'(frame_start), 1);

        // Free run with immediate acks across two full frames
        ack_mode = 1;
        fs_seen = 0; last_fs = 0; hs_low = 0; vs_low = 0; hs_first = -1; vs_first = -1;
        reqs = 0; first_ly = -1; last_ly = -1; last_req_y = -1;
        for (int c = 0; c < 3 * FT + 10 && fs_seen < 3; c++) begin
            if (frame_start) begin
                if (fs_seen > 0) check("fs_period", c - last_fs, FT);
                if (fs_seen == 2) check("frame_at_3rd_fs", int'(frame), 2);
                if (fs_seen == 1) begin
                    check("hsync_low_cycles", hs_low, HS * VT);
                    check("hsync_first_x", hs_first, HA + HF);
                    check("vsync_low_cycles", vs_low, VS * HT);
                    check("vsync_first_y", vs_first, VA + VF);
                    check("reqs_per_frame", reqs, VA);
                    check("first_req_line", first_ly, 1);
                    check("last_req_line", last_ly, 0);
                    check("last_req_from_y", last_req_y, VT - 1);
                end
                fs_seen++;
                last_fs = c;
            end
            if (fs_seen == 1) begin
                if (!hsync) begin
                    hs_low++;
                    if (hs_first < 0) hs_first = int'(x);
                end
                if (!vsync) begin
                    vs_low++;
                    if (vs_first < 0) vs_first = int'(y);
                end
                if (line_req && x == 10'(HA)) begin
                    reqs++;
                    if (first_ly < 0) first_ly = int'(line_y);
                    last_ly = int'(line_y);
                    last_req_y = int'(y);
                end
            end
            step();
        end
        check("fs_count", fs_seen, 3);
        check("free_underrun", int'(underrun), 0);

        // Withhold ack on the request for line 11
        ack_mode = 2;
        wait_pos(HA, 10);
        check("wh_req_start", int'(line_req), 1);
        check("wh_line_y", int'(line_y), 11);
        wait_pos(HT - 1, 10);
        check("wh_req_end", int'(line_req), 1);
        check("wh_und_before", int'(underrun), 0);
        step();
        check("wh_x_wrap", int'(x), 0);
        check("wh_req_drop", int'(line_req), 0);
        check("wh_und_set", int'(underrun), 1);
        wait_pos(5, 3);
        check("wh_und_sticky", int'(underrun), 1);

        // Late ack at line end wins; ack while idle is ignored
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_underrun", int'(underrun), 0);
        ack_mode = 3;
        wait_pos(HA, 2);
        check("idle_ack_ignored", int'(line_req), 1);
        wait_pos(HT - 1, 2);
        check("late_req_held", int'(line_req), 1);
        step();
        check("late_req_drop", int'(line_req), 0);
        check("late_no_underrun", int'(underrun), 0);

        // Freeze for 50 cycles at x=10, y=7
        ack_mode = 1;
        wait_pos(10, 7);
        fr0 = int'(frame);
        run = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (i % 10 == 9) begin
                check("frz_x", int'(x), 10);
                check("frz_y", int'(y), 7);
                check("frz_frame", int'(frame), fr0);
            end
        end
        run = 1'b1;
        step();
        check("resume_x", int'(x), 11);

        // Ack completes a pending request while frozen
        ack_mode = 4;
        line_ack = 1'b0;
        wait_pos(HA + 4, 3);
        check("frz_req_pending", int'(line_req), 1);
        run = 1'b0;
        line_ack = 1'b1;
        step();
        check("frz_ack_done", int'(line_req), 0);
        check("frz_ack_x", int'(x), HA + 4);
        line_ack = 1'b0;
        run = 1'b1;

        // Reset in the middle of an unacknowledged request
        ack_mode = 0;
        wait_pos(25, 8);
        check("mid_req_high", int'(line_req), 1);
        check("mid_und_before", int'(underrun), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_x", int'(x), 0);
        check("mid_rst_y", int'(y), 0);
        check("mid_rst_req", int'(line_req), 0);
        check("mid_rst_und", int'(underrun), 0);
        check("mid_rst_frame", int'(frame), 0);
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timing_sequencer.md
TIMING_SEQUENCER -- requirements
Module: timing_sequencer

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch, pixels.
REQ-003 Parameter H_SYNC, 96, hsync width, pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch; H_TOTAL = sum of H_* = 800.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch, lines.
REQ-007 Parameter V_SYNC, 2, vsync width, lines.
REQ-008 Parameter V_BP, 33, vertical back porch; V_TOTAL = sum of V_* = 525.
REQ-009 clk  input  1  single clock, all state on rising edge.
REQ-010 reset  input  1  synchronous, active-high reset.
REQ-011 run  input  1  1 = counters advance; 0 = all state frozen.
REQ-012 line_ack  input  1  renderer accepts pending line request.
REQ-013 x  output  10  current pixel column.
REQ-014 y  output  10  current line.
REQ-015 active  output  1  high when x < H_ACTIVE and y < V_ACTIVE.
REQ-016 hsync  output  1  active-low horizontal sync.
REQ-017 vsync  output  1  active-low vertical sync.
REQ-018 frame_start  output  1  one-cycle pulse at x = 0, y = 0.
REQ-019 frame  output  8  frame counter.
REQ-020 line_req  output  1  request renderer to prefetch line line_y.
REQ-021 line_y  output  10  line number being requested.
REQ-022 underrun  output  1  sticky: a request expired without ack.

Function
REQ-023 x increments by 1 each cycle with run = 1; at H_TOTAL-1 wraps to 0 and y increments.
REQ-024 y wraps from V_TOTAL-1 to 0 on the same cycle x wraps; frame increments mod 256 on that cycle.
REQ-025 hsync = 0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; vsync = 0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC.
REQ-026 active, hsync, vsync, frame_start decoded from registered x/y with zero added latency; all outputs glitch-free registered or registered-state decodes.
REQ-027 frame_start = 1 only while x = 0, y = 0 and run = 1; with run = 0 it is 0.
REQ-028 Request FSM states: IDLE, REQ; reset state IDLE.
REQ-029 IDLE -> REQ on the cycle x becomes H_ACTIVE, if next line n = (y+1 mod V_TOTAL) < V_ACTIVE; line_y <= n.
REQ-030 In REQ, line_req = 1 and line_y stable; line_ack = 1 -> IDLE next cycle; line_ack ignored in IDLE.
REQ-031 REQ with x = H_TOTAL-1, run = 1 and line_ack = 0 -> IDLE, underrun <= 1; ack on that same cycle wins (no underrun).
REQ-032 Last visible line (y = V_ACTIVE-1) issues no request; line y = V_TOTAL-1 requests line 0.
REQ-033 underrun cleared only by reset.
REQ-034 run = 0 freezes x, y, frame, FSM state and underrun; line_ack still completes a pending REQ.

Reset
REQ-035 reset = 1 at clk edge: x = 0, y = 0, frame = 0, FSM IDLE, line_req = 0, line_y = 0, underrun = 0; overrides run and line_ack.
REQ-036 Outputs after reset: active = 1, hsync = 1, vsync = 1, frame_start = 1 once run = 1.
REQ-037 Reset asserted mid-request drops line_req next cycle without setting underrun.

Verification
REQ-038 Free run 2 frames, ack 1 cycle after each req -> hsync low 96 cycles starting x = 656; vsync low lines 490-491; frame = 2 at third frame_start; 800*525 cycles between frame_start pulses.
REQ-039 Acks always immediate -> exactly 480 requests per frame, line_y 1..479 then 0 (from y = 524), underrun stays 0.
REQ-040 Withhold ack on line y = 10 -> line_req high x = 640..799, drops at x = 0 of y = 11, underrun = 1 and stays 1 afterwards.
REQ-041 Ack exactly at x = 799 -> no underrun; ack at x = 640 in IDLE-before-req pattern ignored.
REQ-042 run = 0 for 50 cycles at x = 100, y = 7 -> x/y/frame unchanged, then resume at x = 101.
REQ-043 reset pulse at x = 700, y = 300 with line_req = 1 -> next cycle x = 0, y = 0, line_req = 0, underrun = 0, frame = 0.
